// File: rtl/interrupt_dispatch_pkg.sv
// Shared CPU interrupt definitions: IRQ bit positions, IF/IE addresses,
// dispatch state encoding and vector arithmetic.
package interrupt_dispatch_pkg;

  localparam int unsigned IrqVblank = 0;
  localparam int unsigned IrqStat   = 1;
  localparam int unsigned IrqTimer  = 2;
  localparam int unsigned IrqSerial = 3;
  localparam int unsigned IrqJoypad = 4;

  localparam logic [15:0] AddrIf = 16'hFF0F;
  localparam logic [15:0] AddrIe = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StWait1,
    StWait2,
    StPushHi,
    StPushLo,
    StJump
  } disp_state_e;

  function automatic logic [15:0] irq_vector(input logic [15:0] base, input logic [2:0] idx);
    return base + {10'b0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/interrupt_dispatch.sv
// IF/IE/IME ownership and the 5 M-cycle interrupt dispatch sequence
// (wait, wait, push PC high, push PC low, load vector) plus HALT wake-up.
module interrupt_dispatch
  import interrupt_dispatch_pkg::*;
#(
  parameter logic [15:0] VECTOR_BASE = 16'h0040,
  parameter int unsigned NUM_IRQ     = 5
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  input  logic               i_M_Cycle,
  input  logic [NUM_IRQ-1:0] i_Irq_Req,
  input  logic               i_IF_We,
  input  logic               i_IE_We,
  input  logic [7:0]         i_Wr_Data,
  output logic [7:0]         o_IF,
  output logic [7:0]         o_IE,
  input  logic               i_EI,
  input  logic               i_DI,
  input  logic               i_RETI,
  input  logic               i_Instr_Boundary,
  input  logic [15:0]        i_PC,
  input  logic [2:0]         i_Vec_Index,
  output logic [NUM_IRQ-1:0] o_Pending,
  output logic               o_Dispatch,
  output logic               o_Push_Req,
  output logic [7:0]         o_Push_Data,
  output logic               o_PC_Load,
  output logic [15:0]        o_PC_Vector,
  output logic               o_Wake
);

  logic [NUM_IRQ-1:0] if_q, if_d, ack_clear, pending;
  logic [7:0]         ie_q, ie_d;
  logic               ime_q, ime_d;
  logic               ei_pend_q, ei_pend_d;
  logic               ei_seen_q, ei_seen_d;
  disp_state_e        state_q, state_d;
  logic               dispatch_q, dispatch_d;
  logic               push_req_q, push_req_d;
  logic [7:0]         push_data_q, push_data_d;
  logic               pc_load_q, pc_load_d;
  logic [15:0]        pc_vector_q, pc_vector_d;
  logic               ei_fire, ime_eff, start, sample;

  assign pending = if_q & ie_q[NUM_IRQ-1:0];
  // EI arms IME only at the second boundary after it, so the next instruction runs.
  assign ei_fire = ei_pend_q & ei_seen_q & i_Instr_Boundary;
  assign ime_eff = ~i_DI & (ime_q | i_RETI | ei_fire);
  assign start   = i_M_Cycle & (state_q == StIdle) & i_Instr_Boundary & ime_eff & (|pending);
  assign sample  = i_M_Cycle & (state_q == StPushLo);

  always_comb begin
    ack_clear = '0;
    if (sample && (|pending)) ack_clear = NUM_IRQ'(1) << i_Vec_Index;
    // Requests are OR-ed in last so they win over a same-cycle write or ack.
    if_d = ((i_IF_We ? i_Wr_Data[NUM_IRQ-1:0] : if_q) & ~ack_clear) | i_Irq_Req;
    ie_d = i_IE_We ? i_Wr_Data : ie_q;
  end

  always_comb begin
    ime_d       = ime_q;
    ei_pend_d   = ei_pend_q;
    ei_seen_d   = ei_seen_q;
    state_d     = state_q;
    push_req_d  = push_req_q;
    push_data_d = push_data_q;
    pc_load_d   = pc_load_q;
    pc_vector_d = pc_vector_q;
    if (i_M_Cycle) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d   = StWait1;
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
            ei_seen_d = 1'b0;
          end else if (i_DI) begin
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
            ei_seen_d = 1'b0;
          end else if (i_RETI) begin
            ime_d = 1'b1;
          end else if (i_EI) begin
            ei_pend_d = 1'b1;
            ei_seen_d = 1'b0;
          end else if (i_Instr_Boundary && ei_pend_q) begin
            if (ei_seen_q) begin
              ime_d     = 1'b1;
              ei_pend_d = 1'b0;
              ei_seen_d = 1'b0;
            end else begin
              ei_seen_d = 1'b1;
            end
          end
        end
        StWait1: state_d = StWait2;
        StWait2: begin
          state_d     = StPushHi;
          push_req_d  = 1'b1;
          push_data_d = i_PC[15:8];
        end
        StPushHi: begin
          state_d     = StPushLo;
          push_data_d = i_PC[7:0];
        end
        StPushLo: begin
          // An empty resample (IE/IF changed mid-sequence) cancels to vector 0.
          state_d     = StJump;
          push_req_d  = 1'b0;
          pc_load_d   = 1'b1;
          pc_vector_d = (|pending) ? irq_vector(VECTOR_BASE, i_Vec_Index) : 16'h0000;
        end
        StJump: begin
          state_d   = StIdle;
          pc_load_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
    dispatch_d = (state_d != StIdle);
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      if_q        <= '0;
      ie_q        <= '0;
      ime_q       <= 1'b0;
      ei_pend_q   <= 1'b0;
      ei_seen_q   <= 1'b0;
      state_q     <= StIdle;
      dispatch_q  <= 1'b0;
      push_req_q  <= 1'b0;
      push_data_q <= '0;
      pc_load_q   <= 1'b0;
      pc_vector_q <= VECTOR_BASE;
    end else begin
      if_q        <= if_d;
      ie_q        <= ie_d;
      ime_q       <= ime_d;
      ei_pend_q   <= ei_pend_d;
      ei_seen_q   <= ei_seen_d;
      state_q     <= state_d;
      dispatch_q  <= dispatch_d;
      push_req_q  <= push_req_d;
      push_data_q <= push_data_d;
      pc_load_q   <= pc_load_d;
      pc_vector_q <= pc_vector_d;
    end
  end

  assign o_IF        = {{(8 - NUM_IRQ){1'b1}}, if_q};
  assign o_IE        = ie_q;
  assign o_Pending   = pending;
  assign o_Wake      = |pending;
  assign o_Dispatch  = dispatch_q;
  assign o_Push_Req  = push_req_q;
  assign o_Push_Data = push_data_q;
  assign o_PC_Load   = pc_load_q;
  assign o_PC_Vector = pc_vector_q;

endmodule

// File: doc/interrupt_dispatch.md
Name: interrupt_dispatch

Overview:
- Upstream of the CPU control unit's interrupt priority encoder.
- Owns the IF (0xFF0F) and IE (0xFFFF) registers and the IME flag, including EI-delay semantics.
- Forms the pending set and drives it to the encoder.
- Runs the 5 M-cycle interrupt dispatch sequence: two wait cycles, push PC high, push PC low, load vector. Also generates HALT wake-up.

Parameters:
- VECTOR_BASE, 16'h0040, address of interrupt 0; vector = VECTOR_BASE + 8*index.
- NUM_IRQ, 5, number of interrupt sources (VBlank, STAT, Timer, Serial, Joypad).

Ports:
- i_Clk  in  1  system clock.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_M_Cycle  in  1  one-clock strobe marking each M-cycle boundary; all state advances gated by it.
- i_Irq_Req  in  5  peripheral request pulses; set IF bits.
- i_IF_We  in  1  CPU write strobe to IF.
- i_IE_We  in  1  CPU write strobe to IE.
- i_Wr_Data  in  8  write data.
- o_IF  out  8  readback: {3'b111, IF[4:0]}.
- o_IE  out  8  readback: full 8-bit IE.
- i_EI  in  1  EI executed (M-cycle strobe).
- i_DI  in  1  DI executed.
- i_RETI  in  1  RETI executed.
- i_Instr_Boundary  in  1  high in the M-cycle where the next opcode fetch would begin.
- i_PC  in  16  current PC.
- i_Vec_Index  in  3  index returned by the priority encoder.
- o_Pending  out  5  IF[4:0] & IE[4:0], to the encoder.
- o_Dispatch  out  1  high while the sequence runs; suppresses fetch.
- o_Push_Req  out  1  stack-push request for this M-cycle.
- o_Push_Data  out  8  byte to push.
- o_PC_Load  out  1  load o_PC_Vector into PC.
- o_PC_Vector  out  16  target vector.
- o_Wake  out  1  |o_Pending; exits HALT independent of IME.

Behaviour:
- Reset (async, low): IF=0, IE=0, IME=0, ei_pend=0, state IDLE; o_Dispatch, o_Push_Req, o_PC_Load = 0; o_Push_Data=0; o_PC_Vector=VECTOR_BASE.
- IF update, every clock (not M-cycle gated): IF_next = (i_IF_We ? i_Wr_Data[4:0] : IF) & ~ack_clear | i_Irq_Req.
  - A simultaneous request and write/clear on the same bit: the request wins.
- IE: written on i_IE_We.
- IME, applied on i_M_Cycle:
  - DI clears IME and ei_pend.
  - RETI sets IME immediately.
  - EI sets ei_pend. IME becomes 1 at the next i_Instr_Boundary after the one that follows EI, so the instruction after EI is never interrupted.
  - EI;DI leaves IME=0.
- Dispatch start: in IDLE on i_M_Cycle with i_Instr_Boundary & IME & |o_Pending. The start cycle clears IME and ei_pend.
- FSM, one state per M-cycle, advancing on i_M_Cycle:
  - IDLE -> WAIT1 -> WAIT2 -> PUSH_HI -> PUSH_LO -> JUMP -> IDLE.
  - o_Dispatch is 1 in every state except IDLE.
  - PUSH_HI: o_Push_Req=1, o_Push_Data=i_PC[15:8].
  - PUSH_LO: o_Push_Req=1, o_Push_Data=i_PC[7:0]. Pending is resampled here.
    - If pending is nonzero, latch i_Vec_Index and clear that IF bit (ack_clear one-hot, single clock).
    - If pending is zero (IE/IF changed by the high-byte push or a CPU write), latch cancel: no IF bit cleared.
  - JUMP: o_PC_Load=1 for one M-cycle, o_PC_Vector = VECTOR_BASE + {index,3'b000}, or 16'h0000 if cancelled.
- Latency: start to o_PC_Load = 5 M-cycles.
- IF/IE writes and new requests during dispatch are accepted normally; only the PUSH_LO sample affects the vector.
- i_EI/i_DI/i_RETI during dispatch are ignored; they cannot occur, and the bench asserts this.
- o_Wake is combinational from registered IF/IE.
- Reset mid-dispatch returns to IDLE immediately; outputs take reset values.

Decomposition:
- Shared CPU package holds:
  - the IRQ bit positions (VBLANK=0, STAT=1, TIMER=2, SERIAL=3, JOYPAD=4);
  - the IF/IE addresses;
  - the dispatch state encoding (3-bit: IDLE, WAIT1, WAIT2, PUSH_HI, PUSH_LO, JUMP).
- The priority encoder stays a separate module (Interrupt_Address), instantiated by the control-unit top alongside this block, not inside it.
- No further sub-module.

Test Plan:
- IE=0x04, IME=1, pulse i_Irq_Req=5'b00100 at PC=0x1234 -> at the next boundary:
  - pushes 0x12 then 0x34;
  - o_PC_Load with vector 0x0050 five M-cycles after start;
  - IF[2] cleared, IME=0.
- IE=0x1F, IF=0x18 (Serial+Joypad) -> encoder index 3, vector 0x0058; IF becomes 0x10; o_IF reads 0xF0.
- EI then NOP with IF&IE≠0 -> NOP completes uninterrupted; dispatch starts at the boundary after NOP. EI;DI -> no dispatch.
- Cancel: IE write to 0x00 during PUSH_HI -> vector 0x0000, IF unchanged.
- IF write 0x00 in the same clock as i_Irq_Req[0] -> IF[0]=1. With IME=0 and pending≠0 -> o_Wake=1, no dispatch.
- Assert i_Reset_n low during PUSH_LO -> o_Dispatch=0, IF=IE=0, IME=0 immediately. No o_PC_Load after release.
